// File: rtl/axi_node_err_pkg.sv
// Shared definitions for the AXI node error responders (AR/AW sides).
package axi_node_err_pkg;

  localparam logic [1:0] RESP_DECERR   = 2'b11;
  localparam int         AXI_LEN_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SEND  = 2'd2
  } err_state_t;

endpackage

// File: rtl/axi_outstanding_counter.sv
// Saturating in-flight burst counter; exposes only "non-empty" and "full".
// Shared between the AR/R and AW/B error responders.
module axi_outstanding_counter #(
  parameter int MAX_OUT   = 8,
  parameter int CNT_WIDTH = $clog2(MAX_OUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic incr_i,
  input  logic decr_i,
  output logic outstanding_o,
  output logic full_o
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUT);

  logic [CNT_WIDTH-1:0] cnt_q;

  // Count up on accept, down on last-beat return; simultaneous events cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (incr_i && !decr_i) begin
      if (cnt_q != MAX_CNT) cnt_q <= cnt_q + 1'b1;
    end else if (decr_i && !incr_i) begin
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Overflow/underflow mean the decoder broke its own flow control; report, then hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(incr_i && !decr_i && cnt_q == MAX_CNT))
        else $warning("outstanding counter: incr at max, holding");
      assert (!(decr_i && !incr_i && cnt_q == '0))
        else $warning("outstanding counter: decr at zero, holding");
    end
  end

  assign outstanding_o = (cnt_q != '0);
  assign full_o        = (cnt_q == MAX_CNT);

endmodule

// File: rtl/axi_ar_decerr_responder.sv
// AR-side DECERR responder: tracks in-flight reads for the address decoder
// and, on an erroneous AR, waits for the real slaves to drain before
// returning an ARLEN+1 beat DECERR burst on R, then grants the decoder.
// Optional build macro AXI_DECERR_STATS_EN adds decerr_count_o, a
// saturating count of completed DECERR bursts.
module axi_ar_decerr_responder
  import axi_node_err_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_OUT    = 8,
  parameter int CNT_WIDTH  = $clog2(MAX_OUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  incr_req_i,
  input  logic                  decr_req_i,
  output logic                  outstanding_trans_o,
  output logic                  full_counter_o,
  input  logic                  sample_ardata_info_i,
  input  logic [ID_WIDTH-1:0]   arid_i,
  input  logic [7:0]            arlen_i,
  input  logic                  error_req_i,
  output logic                  error_gnt_o,
  output logic                  err_rvalid_o,
  input  logic                  err_rready_i,
  output logic [ID_WIDTH-1:0]   err_rid_o,
  output logic [DATA_WIDTH-1:0] err_rdata_o,
  output logic [1:0]            err_rresp_o,
  output logic                  err_rlast_o
`ifdef AXI_DECERR_STATS_EN
  ,
  output logic [15:0]           decerr_count_o
`endif
);

  err_state_t               state_q;
  logic [AXI_LEN_WIDTH-1:0] beat_q;
  logic [AXI_LEN_WIDTH-1:0] len_q;
  logic [ID_WIDTH-1:0]      id_q;
  logic                     drained;

  axi_outstanding_counter #(
    .MAX_OUT   (MAX_OUT),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk           (clk),
    .rst           (rst),
    .incr_i        (incr_req_i),
    .decr_i        (decr_req_i),
    .outstanding_o (outstanding_trans_o),
    .full_o        (full_counter_o)
  );

  // Only leave DRAIN on a quiet cycle so a late incr/decr cannot race the burst.
  assign drained = !outstanding_trans_o && !incr_req_i && !decr_req_i;

  // Error FSM: latch the bad AR, wait for drain, stream the DECERR beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (sample_ardata_info_i) begin
          id_q    <= arid_i;
          len_q   <= arlen_i;
          beat_q  <= '0;
          state_q <= DRAIN;
        end
        DRAIN: if (drained) state_q <= SEND;
        SEND: if (err_rready_i) begin
          if (beat_q == len_q) state_q <= IDLE;
          else                 beat_q  <= beat_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Decoder protocol checks: a sample must come with an error request, and only in IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(sample_ardata_info_i && state_q != IDLE))
        else $error("decerr responder: sample while busy ignored");
      assert (!sample_ardata_info_i || error_req_i)
        else $error("decerr responder: sample without error_req");
    end
  end

  // Everything on R is decoded from held state, so it stays stable under stall.
  assign err_rvalid_o = (state_q == SEND);
  assign err_rlast_o  = err_rvalid_o && (beat_q == len_q);
  assign err_rid_o    = id_q;
  assign err_rdata_o  = '0;
  assign err_rresp_o  = RESP_DECERR;
  assign error_gnt_o  = err_rvalid_o && err_rready_i && err_rlast_o;

`ifdef AXI_DECERR_STATS_EN
  logic [15:0] stat_q;

  // Completed bursts only; a reset-aborted burst never grants so never counts.
  always_ff @(posedge clk) begin
    if (rst)                                   stat_q <= '0;
    else if (error_gnt_o && stat_q != 16'hFFFF) stat_q <= stat_q + 1'b1;
  end

  assign decerr_count_o = stat_q;
`endif

endmodule
